// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the MIPS fetch stage.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect targets trap to EXC_VECTOR).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic        Flush,
    output logic        AlignFault
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_fetch_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic [31:0] w_redirect_pc;

    // Branch outranks jump; the losing target is simply not selected.
    assign w_redirect = (r_state != S_RESET) && (BranchTaken || Jump);
    assign w_target   = BranchTaken ? BranchTarget : JumpTarget;

`ifdef PC_ALIGN_CHECK_EN
    logic r_align_fault;

    assign w_misaligned = (w_target[1:0] != 2'b00);
    assign AlignFault   = r_align_fault;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_align_fault <= 1'b0;
        end else if (w_redirect && w_misaligned) begin
            r_align_fault <= 1'b1;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign AlignFault   = 1'b0;
`endif

    assign w_redirect_pc = w_misaligned ? EXC_VECTOR : w_target;

    // Combinational so the IF/ID register squashes the wrong-path fetch this cycle.
    assign Flush = Rst && w_redirect;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_PC;
            r_fetch_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_RESET: begin
                    r_state       <= S_RUN;
                    r_fetch_valid <= 1'b1;
                end
                S_RUN, S_HOLD: begin
                    if (w_redirect) begin
                        r_state <= S_RUN;
                        r_pc    <= w_redirect_pc;
                    end else if (Stall) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_RUN;
                        // Adder output taken verbatim; wrap past 0xFFFF_FFFC is silent.
                        r_pc    <= PCAddResult;
                    end
                end
                default: begin
                    r_state       <= S_RESET;
                    r_pc          <= RESET_PC;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign PCResult   = r_pc;
    assign FetchValid = r_fetch_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model of the fetch PC.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] PCResult;
    logic        FetchValid;
    logic        Flush;
    logic        AlignFault;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural PC, valid flag, sticky fault, and whether
    // the next edge is the first one after reset release.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_fault;
    bit          m_first_after_reset;

    pc_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .PCAddResult (PCAddResult),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .PCResult    (PCResult),
        .FetchValid  (FetchValid),
        .Flush       (Flush),
        .AlignFault  (AlignFault)
    );

    always #5 Clk = ~Clk;

    function automatic logic model_flush();
        return Rst && !m_first_after_reset && (BranchTaken || Jump);
    endfunction

    // Advance one clock, apply the fetch rules to the model, then present PC+4 as the adder would.
    task automatic tick();
        logic [31:0] t;
        @(posedge Clk);
        if (!Rst) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_fault = 1'b0; m_first_after_reset = 1'b1;
        end else if (m_first_after_reset) begin
            m_first_after_reset = 1'b0; m_valid = 1'b1;
        end else if (BranchTaken || Jump) begin
            t = BranchTaken ? BranchTarget : JumpTarget;
            if (ALIGN_CHK && (t % 4 != 0)) begin
                m_pc = EXC_VECTOR; m_fault = 1'b1;
            end else begin
                m_pc = t;
            end
        end else if (!Stall) begin
            m_pc = PCAddResult;
        end
        #1;
        PCAddResult = m_pc + 32'd4;
    endtask

    task automatic idle_inputs();
        Stall = 0; BranchTaken = 0; Jump = 0; BranchTarget = 0; JumpTarget = 0;
    endtask

    task automatic test_reset();
        logic [31:0] seq [4];
        seq[0] = 32'd0; seq[1] = 32'd4; seq[2] = 32'd8; seq[3] = 32'd12;
        idle_inputs();
        Rst = 0;
        PCAddResult = 32'h1234_5678;
        repeat (3) tick();
        n_cmp++;
        if (PCResult !== RESET_PC || FetchValid !== 1'b0 || AlignFault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: pc=%h valid=%b fault=%b required pc=%h valid=0 fault=0",
                     PCResult, FetchValid, AlignFault, RESET_PC);
        end
        BranchTaken = 1; BranchTarget = 32'h40;
        #1;
        n_cmp++;
        if (Flush !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush: flush=%b required 0", Flush);
        end
        BranchTaken = 0;
        Rst = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (PCResult !== seq[i] || PCResult !== m_pc || FetchValid !== 1'b1) begin
                n_fail++;
                $display("FAIL release_seq[%0d]: pc=%h valid=%b required pc=%h valid=1",
                         i, PCResult, FetchValid, seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        Jump = 1; JumpTarget = 32'h0C;
        tick();
        Jump = 0;
        tick();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (Flush !== 1'b0) begin
                n_fail++; $display("FAIL stall_flush[%0d]: flush=%b required 0", i, Flush);
            end
            tick();
            n_cmp++;
            if (PCResult !== 32'h10 || FetchValid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: pc=%h valid=%b required pc=00000010 valid=1",
                         i, PCResult, FetchValid);
            end
        end
        Stall = 0;
        tick();
        n_cmp++;
        if (PCResult !== 32'h14) begin
            n_fail++; $display("FAIL stall_resume: pc=%h required 00000014", PCResult);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        Jump = 1; JumpTarget = 32'h1C;
        tick();
        Jump = 0;
        tick();
        n_cmp++;
        if (PCResult !== 32'h20) begin
            n_fail++; $display("FAIL prio_setup: pc=%h required 00000020", PCResult);
        end
        BranchTaken = 1; BranchTarget = 32'h100;
        Jump = 1; JumpTarget = 32'h200; Stall = 1;
        #1;
        n_cmp++;
        if (Flush !== 1'b1) begin
            n_fail++; $display("FAIL prio_flush: flush=%b required 1", Flush);
        end
        tick();
        idle_inputs();
        n_cmp++;
        if (PCResult !== 32'h100 || FetchValid !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_pc: pc=%h valid=%b required pc=00000100 valid=1",
                     PCResult, FetchValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tg [3];
        tg[0] = 32'h400; tg[1] = 32'h800; tg[2] = 32'hC00;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            BranchTaken = (i != 1); BranchTarget = tg[i];
            Jump = (i == 1); JumpTarget = tg[i];
            #1;
            n_cmp++;
            if (Flush !== 1'b1) begin
                n_fail++; $display("FAIL b2b_flush[%0d]: flush=%b required 1", i, Flush);
            end
            tick();
            n_cmp++;
            if (PCResult !== tg[i]) begin
                n_fail++; $display("FAIL b2b_pc[%0d]: pc=%h required %h", i, PCResult, tg[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        idle_inputs();
        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        tick();
        Jump = 0;
        n_cmp++;
        if (PCResult !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_setup: pc=%h required fffffffc", PCResult);
        end
        tick();
        n_cmp++;
        if (PCResult !== 32'h0 || AlignFault !== 1'b0 || FetchValid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: pc=%h fault=%b valid=%b required pc=00000000 fault=0 valid=1",
                     PCResult, AlignFault, FetchValid);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] exp_pc;
        logic        exp_fault;
        exp_pc    = ALIGN_CHK ? 32'h80 : 32'h202;
        exp_fault = ALIGN_CHK;
        idle_inputs();
        Jump = 1; JumpTarget = 32'h202;
        #1;
        n_cmp++;
        if (Flush !== 1'b1) begin
            n_fail++; $display("FAIL misalign_flush: flush=%b required 1", Flush);
        end
        tick();
        Jump = 0;
        n_cmp++;
        if (PCResult !== exp_pc || AlignFault !== exp_fault) begin
            n_fail++;
            $display("FAIL misalign: pc=%h fault=%b required pc=%h fault=%b",
                     PCResult, AlignFault, exp_pc, exp_fault);
        end
        repeat (3) tick();
        n_cmp++;
        if (AlignFault !== exp_fault || PCResult !== exp_pc + 32'd12) begin
            n_fail++;
            $display("FAIL misalign_sticky: pc=%h fault=%b required pc=%h fault=%b",
                     PCResult, AlignFault, exp_pc + 32'd12, exp_fault);
        end
    endtask

    task automatic test_reset_mid_redirect();
        idle_inputs();
        BranchTaken = 1; BranchTarget = 32'h300;
        Rst = 0;
        #1;
        n_cmp++;
        if (Flush !== 1'b0) begin
            n_fail++; $display("FAIL rst_redir_flush: flush=%b required 0", Flush);
        end
        tick();
        n_cmp++;
        if (PCResult !== RESET_PC || FetchValid !== 1'b0 || AlignFault !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_redir_pc: pc=%h valid=%b fault=%b required pc=%h valid=0 fault=0",
                     PCResult, FetchValid, AlignFault, RESET_PC);
        end
        // First cycle after release ignores the still-asserted branch.
        Rst = 1;
        #1;
        n_cmp++;
        if (Flush !== 1'b0) begin
            n_fail++; $display("FAIL sreset_flush: flush=%b required 0", Flush);
        end
        tick();
        n_cmp++;
        if (PCResult !== RESET_PC || FetchValid !== 1'b1) begin
            n_fail++;
            $display("FAIL sreset_ignore: pc=%h valid=%b required pc=%h valid=1",
                     PCResult, FetchValid, RESET_PC);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            Rst          = ($urandom_range(0, 63) != 0);
            Stall        = ($urandom_range(0, 3) == 0);
            BranchTaken  = ($urandom_range(0, 5) == 0);
            Jump         = ($urandom_range(0, 5) == 0);
            BranchTarget = $urandom & ~32'h3;
            JumpTarget   = $urandom & ~32'h3;
            if ($urandom_range(0, 7) == 0) BranchTarget[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) JumpTarget[1:0] = 2'($urandom_range(1, 3));
            #1;
            n_cmp++;
            if (Flush !== model_flush()) begin
                n_fail++;
                $display("FAIL rand_flush[%0d]: flush=%b required %b", i, Flush, model_flush());
            end
            tick();
            n_cmp++;
            if (PCResult !== m_pc || FetchValid !== m_valid || AlignFault !== m_fault) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: pc=%h valid=%b fault=%b required pc=%h valid=%b fault=%b",
                         i, PCResult, FetchValid, AlignFault, m_pc, m_valid, m_fault);
            end
        end
        Rst = 1;
        idle_inputs();
    endtask

    initial begin
        m_pc = RESET_PC; m_valid = 0; m_fault = 0; m_first_after_reset = 1;
        Rst = 0;
        idle_inputs();
        PCAddResult = 0;
        #2;
        test_reset();
        test_stall();
        test_priority();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_reset_mid_redirect();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
